dlx_pipe_ctrl: RTL and testbench

Pipeline interlock and sequencing controller for the DLX 5-stage core.
- Watches the instruction in ID and the destinations in ID/EX and EX/MEM.
- Generates the global stall, the ID/EX bubble, the IF/ID flush and the ID operand-A forwarding select.
- Sequences data-cache wait, halt drain and illegal-instruction trap.
- Sits beside dlx_pipe_id. Drives its stall and id_a_fwd_sel inputs and consumes its classification outputs.

---
 rtl/dlx_global_pkg.sv | 8 +
 rtl/dlx_pipe_ctrl_hazard.sv | 35 +++
 rtl/dlx_pipe_ctrl.sv | 97 +++++++++
 tb/tb_dlx_pipe_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dlx_global_pkg.sv
// dlx_global_pkg: shared opcode classes, forwarding selects and pipe-control states
package dlx_global_pkg;
    typedef enum logic [2:0] {
        CLASS_LOAD, CLASS_STORE, CLASS_BRANCH, CLASS_JUMP, CLASS_RTYPE, CLASS_ITYPE, CLASS_NOP
    } opcode_class_e;
    typedef enum logic [1:0] {FWDSEL_REGFILE, FWDSEL_EX_MEM_ALU_OUT} fwd_select_e;
    typedef enum logic [2:0] {RUN, INTLK, DCWAIT, DRAIN, HALTED, TRAP} pipe_ctrl_state_e;
endpackage

// File: rtl/dlx_pipe_ctrl_hazard.sv
// dlx_hazard_detect: combinational ID-stage hazard flags, interlock length and operand-A forward select
module dlx_hazard_detect
    import dlx_global_pkg::*;
(
    input  logic [2:0] id_opcode_class,
    input  logic [4:0] id_ir_rs1,
    input  logic [4:0] id_ir_rs2,
    input  logic [2:0] id_ex_opcode_class,
    input  logic [4:0] id_ex_reg_rd,
    input  logic       id_ex_reg_wen,
    input  logic [2:0] ex_mem_opcode_class,
    input  logic [4:0] ex_mem_reg_rd,
    input  logic       ex_mem_reg_wen,
    output logic       load_use,
    output logic       br_alu,
    output logic       br_ld_mem,
    output logic [1:0] req_cnt,
    output logic [1:0] id_a_fwd_sel
);
    logic use_rs1, use_rs2, id_branch, ex_rs1, ex_rs2, mem_rs1;
    always_comb begin
        use_rs1      = id_opcode_class != CLASS_JUMP && id_opcode_class != CLASS_NOP;
        use_rs2      = id_opcode_class == CLASS_RTYPE || id_opcode_class == CLASS_STORE;
        id_branch    = id_opcode_class == CLASS_BRANCH;
        // R0 is hardwired, so a write to it never creates a dependency
        ex_rs1       = id_ex_reg_wen && id_ex_reg_rd != 5'd0 && id_ex_reg_rd == id_ir_rs1;
        ex_rs2       = id_ex_reg_wen && id_ex_reg_rd != 5'd0 && id_ex_reg_rd == id_ir_rs2;
        mem_rs1      = ex_mem_reg_wen && ex_mem_reg_rd != 5'd0 && ex_mem_reg_rd == id_ir_rs1;
        load_use     = id_ex_opcode_class == CLASS_LOAD && ((use_rs1 && ex_rs1) || (use_rs2 && ex_rs2));
        br_alu       = id_branch && id_ex_opcode_class != CLASS_LOAD && ex_rs1;
        br_ld_mem    = id_branch && ex_mem_opcode_class == CLASS_LOAD && mem_rs1;
        req_cnt      = (load_use && id_branch) ? 2'd2 : 2'd1;
        id_a_fwd_sel = (mem_rs1 && ex_mem_opcode_class != CLASS_LOAD) ? FWDSEL_EX_MEM_ALU_OUT : FWDSEL_REGFILE;
    end
endmodule

// File: rtl/dlx_pipe_ctrl.sv
// dlx_pipe_ctrl: DLX pipeline interlock, cache-wait, halt-drain and trap sequencer
module dlx_pipe_ctrl
    import dlx_global_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int HALT_DRAIN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_opcode_class,
    input  logic [4:0]       id_ir_rs1,
    input  logic [4:0]       id_ir_rs2,
    input  logic             id_cond,
    input  logic             id_halt,
    input  logic             id_illegal_instr,
    input  logic [2:0]       id_ex_opcode_class,
    input  logic [4:0]       id_ex_reg_rd,
    input  logic             id_ex_reg_wen,
    input  logic [2:0]       ex_mem_opcode_class,
    input  logic [4:0]       ex_mem_reg_rd,
    input  logic             ex_mem_reg_wen,
    input  logic             dc_wait,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       id_a_fwd_sel,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(HALT_DRAIN + 3);
    pipe_ctrl_state_e state_q, state_d, ret_q, ret_d, cur;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic load_use, br_alu, br_ld_mem;
    logic [1:0] req_cnt;
    dlx_hazard_detect u_hazard (
        .id_opcode_class(id_opcode_class), .id_ir_rs1(id_ir_rs1), .id_ir_rs2(id_ir_rs2),
        .id_ex_opcode_class(id_ex_opcode_class), .id_ex_reg_rd(id_ex_reg_rd), .id_ex_reg_wen(id_ex_reg_wen),
        .ex_mem_opcode_class(ex_mem_opcode_class), .ex_mem_reg_rd(ex_mem_reg_rd), .ex_mem_reg_wen(ex_mem_reg_wen),
        .load_use(load_use), .br_alu(br_alu), .br_ld_mem(br_ld_mem), .req_cnt(req_cnt),
        .id_a_fwd_sel(id_a_fwd_sel)
    );
    always_comb begin
        // the cycle the cache releases behaves as the saved state, so no extra stall is added
        cur          = (state_q == DCWAIT && !dc_wait) ? ret_q : state_q;
        state_d      = cur;
        ret_d        = ret_q;
        wcnt_d       = wcnt_q;
        stall        = 1'b1;
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b0;
        if (dc_wait && (cur == RUN || cur == INTLK || cur == DRAIN)) begin
            id_ex_bubble = 1'b0;
            state_d      = DCWAIT;
            ret_d        = cur;
        end else if (cur == DCWAIT) begin
            id_ex_bubble = 1'b0;
        end else if (cur == RUN) begin
            if (id_illegal_instr) begin
                state_d = TRAP;
            end else if (id_halt) begin
                id_ex_bubble = 1'b0;
                wcnt_d       = WC_W'(HALT_DRAIN);
                state_d      = DRAIN;
            end else if (load_use || br_alu || br_ld_mem) begin
                wcnt_d  = WC_W'(req_cnt - 2'd1);
                state_d = req_cnt > 2'd1 ? INTLK : RUN;
            end else begin
                stall        = 1'b0;
                id_ex_bubble = 1'b0;
                if_id_flush  = id_cond;
            end
        end else if (cur == INTLK || cur == DRAIN) begin
            wcnt_d  = wcnt_q == '0 ? '0 : wcnt_q - WC_W'(1);
            state_d = wcnt_q > WC_W'(1) ? cur : (cur == DRAIN ? HALTED : RUN);
        end
        stall_cnt_d = (stall && state_q != HALTED && state_q != TRAP && !(&stall_cnt_q))
                      ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign halted    = state_q == HALTED;
    assign trap      = state_q == TRAP;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// tb_dlx_pipe_ctrl: directed literal checks plus randomized run against a cycle-level behavioural model
module tb_dlx_pipe_ctrl;
    import dlx_global_pkg::*;
    localparam int CW  = 4;
    localparam int HD  = 3;
    localparam int SAT = (1 << CW) - 1;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] id_opcode_class, id_ex_opcode_class, ex_mem_opcode_class;
    logic [4:0] id_ir_rs1, id_ir_rs2, id_ex_reg_rd, ex_mem_reg_rd;
    logic id_cond, id_halt, id_illegal_instr, id_ex_reg_wen, ex_mem_reg_wen, dc_wait;
    logic stall, id_ex_bubble, if_id_flush, halted, trap;
    logic [1:0] id_a_fwd_sel;
    logic [CW-1:0] stall_cnt;
    int checks = 0, failures = 0;
    int m_owe, m_cnt, n;
    bit m_drain, m_halted, m_trap, m_live = 1'b0, es, eb, ef, nh, nt;

    dlx_pipe_ctrl #(.CNT_W(CW), .HALT_DRAIN(HD)) dut (
        .clk(clk), .rst(rst), .id_opcode_class(id_opcode_class), .id_ir_rs1(id_ir_rs1),
        .id_ir_rs2(id_ir_rs2), .id_cond(id_cond), .id_halt(id_halt), .id_illegal_instr(id_illegal_instr),
        .id_ex_opcode_class(id_ex_opcode_class), .id_ex_reg_rd(id_ex_reg_rd), .id_ex_reg_wen(id_ex_reg_wen),
        .ex_mem_opcode_class(ex_mem_opcode_class), .ex_mem_reg_rd(ex_mem_reg_rd),
        .ex_mem_reg_wen(ex_mem_reg_wen), .dc_wait(dc_wait), .stall(stall), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .id_a_fwd_sel(id_a_fwd_sel), .halted(halted), .trap(trap),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // total stall cycles an ID-stage hazard costs, 0 when there is none
    function automatic int need();
        bit u1 = id_opcode_class != CLASS_JUMP && id_opcode_class != CLASS_NOP;
        bit u2 = id_opcode_class == CLASS_RTYPE || id_opcode_class == CLASS_STORE;
        bit br = id_opcode_class == CLASS_BRANCH;
        bit e1 = id_ex_reg_wen && id_ex_reg_rd != 0 && id_ex_reg_rd == id_ir_rs1;
        bit e2 = id_ex_reg_wen && id_ex_reg_rd != 0 && id_ex_reg_rd == id_ir_rs2;
        bit m1 = ex_mem_reg_wen && ex_mem_reg_rd != 0 && ex_mem_reg_rd == id_ir_rs1;
        if (id_ex_opcode_class == CLASS_LOAD && ((u1 && e1) || (u2 && e2))) return br ? 2 : 1;
        if (br && ((id_ex_opcode_class != CLASS_LOAD && e1) || (ex_mem_opcode_class == CLASS_LOAD && m1))) return 1;
        return 0;
    endfunction

    function automatic int fwd_exp();
        return (ex_mem_reg_wen && ex_mem_reg_rd != 0 && ex_mem_reg_rd == id_ir_rs1
                && ex_mem_opcode_class != CLASS_LOAD) ? int'(FWDSEL_EX_MEM_ALU_OUT) : int'(FWDSEL_REGFILE);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_owe = 0; m_cnt = 0; m_drain = 0; m_halted = 0; m_trap = 0; m_live = 1'b1;
        end else if (m_live) begin
            chk("m_halted", halted, m_halted);
            chk("m_trap", trap, m_trap);
            chk("m_stall_cnt", stall_cnt, m_cnt);
            chk("m_fwd_sel", id_a_fwd_sel, fwd_exp());
            nh = m_halted; nt = m_trap; es = 1; eb = 1; ef = 0;
            if (!(m_halted || m_trap)) begin
                if (dc_wait) eb = 0;
                else if (m_owe > 0) begin
                    m_owe--;
                    if (m_owe == 0 && m_drain) nh = 1;
                end else if (id_illegal_instr) nt = 1;
                else if (id_halt) begin
                    eb = 0; m_owe = HD; m_drain = 1;
                end else begin
                    n = need();
                    if (n > 0) m_owe = n - 1;
                    else begin es = 0; eb = 0; ef = id_cond; end
                end
            end
            chk("m_stall", stall, es);
            chk("m_bubble", id_ex_bubble, eb);
            chk("m_flush", if_id_flush, ef);
            if (es && !m_halted && !m_trap && m_cnt < SAT) m_cnt++;
            m_halted = nh; m_trap = nt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_opcode_class = CLASS_NOP; id_ir_rs1 = 0; id_ir_rs2 = 0; id_cond = 0; id_halt = 0;
        id_illegal_instr = 0; id_ex_opcode_class = CLASS_NOP; id_ex_reg_rd = 0; id_ex_reg_wen = 0;
        ex_mem_opcode_class = CLASS_NOP; ex_mem_reg_rd = 0; ex_mem_reg_wen = 0; dc_wait = 0;
    endtask

    initial begin
        idle();
        repeat (3) step();
        rst = 0; #1;
        chk("rst_stall", stall, 0); chk("rst_bubble", id_ex_bubble, 0); chk("rst_flush", if_id_flush, 0);
        chk("rst_fwd", id_a_fwd_sel, 0); chk("rst_halted", halted, 0); chk("rst_trap", trap, 0);
        chk("rst_cnt", stall_cnt, 0);
        // LW r3 ; ADD r4,r3,r5
        step(); idle(); id_opcode_class = CLASS_RTYPE; id_ir_rs1 = 3; id_ir_rs2 = 5;
        id_ex_opcode_class = CLASS_LOAD; id_ex_reg_rd = 3; id_ex_reg_wen = 1; #1;
        chk("lu_stall", stall, 1); chk("lu_bubble", id_ex_bubble, 1);
        step(); id_ex_opcode_class = CLASS_NOP; id_ex_reg_wen = 0; id_ex_reg_rd = 0;
        ex_mem_opcode_class = CLASS_LOAD; ex_mem_reg_rd = 3; ex_mem_reg_wen = 1; #1;
        chk("lu_release", stall, 0);
        // LW r3 ; BEQZ r3
        step(); idle(); id_opcode_class = CLASS_BRANCH; id_ir_rs1 = 3;
        id_ex_opcode_class = CLASS_LOAD; id_ex_reg_rd = 3; id_ex_reg_wen = 1; #1;
        chk("bl_stall0", stall, 1);
        step(); id_ex_opcode_class = CLASS_NOP; id_ex_reg_wen = 0;
        ex_mem_opcode_class = CLASS_LOAD; ex_mem_reg_rd = 3; ex_mem_reg_wen = 1; #1;
        chk("bl_stall1", stall, 1); chk("bl_bubble1", id_ex_bubble, 1);
        step(); ex_mem_opcode_class = CLASS_NOP; ex_mem_reg_wen = 0; #1;
        chk("bl_release", stall, 0);
        chk("cnt_after_bl", stall_cnt, 3);
        // same with a 3-cycle cache wait inside the interlock
        step(); idle(); id_opcode_class = CLASS_BRANCH; id_ir_rs1 = 3;
        id_ex_opcode_class = CLASS_LOAD; id_ex_reg_rd = 3; id_ex_reg_wen = 1; #1;
        chk("dw_stall0", stall, 1);
        step(); id_ex_opcode_class = CLASS_NOP; id_ex_reg_wen = 0;
        ex_mem_opcode_class = CLASS_LOAD; ex_mem_reg_rd = 3; ex_mem_reg_wen = 1; dc_wait = 1; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            chk("dw_stall", stall, 1); chk("dw_bubble", id_ex_bubble, 0);
        end
        step(); dc_wait = 0; #1;
        chk("dw_resume_stall", stall, 1); chk("dw_resume_bubble", id_ex_bubble, 1);
        step(); ex_mem_opcode_class = CLASS_NOP; ex_mem_reg_wen = 0; #1;
        chk("dw_release", stall, 0);
        chk("cnt_after_dw", stall_cnt, 8);
        // ADD r7 in EX/MEM ; BNEZ r7
        step(); idle(); id_opcode_class = CLASS_BRANCH; id_ir_rs1 = 7;
        ex_mem_opcode_class = CLASS_RTYPE; ex_mem_reg_rd = 7; ex_mem_reg_wen = 1; #1;
        chk("fwd_r7", id_a_fwd_sel, 1); chk("fwd_r7_stall", stall, 0);
        step(); id_ir_rs1 = 0; ex_mem_reg_rd = 0; #1;
        chk("fwd_r0", id_a_fwd_sel, 0);
        // taken branch, no hazard
        step(); idle(); id_opcode_class = CLASS_BRANCH; id_ir_rs1 = 1; id_cond = 1; #1;
        chk("tb_flush", if_id_flush, 1); chk("tb_stall", stall, 0);
        step(); idle(); #1;
        chk("tb_flush_off", if_id_flush, 0);
        // halt drain
        step(); id_halt = 1; #1;
        chk("halt_stall", stall, 1); chk("halt_bubble", id_ex_bubble, 0);
        for (int i = 0; i < 3; i++) begin
            step(); id_halt = 0; #1;
            chk("drain_halted", halted, 0); chk("drain_stall", stall, 1);
        end
        step(); chk("halted_set", halted, 1); chk("halt_cnt", stall_cnt, 12);
        step(); step(); chk("halt_cnt_frozen", stall_cnt, 12); chk("halted_stall", stall, 1);
        step(); rst = 1;
        step(); rst = 0; #1;
        chk("rst2_halted", halted, 0); chk("rst2_cnt", stall_cnt, 0); chk("rst2_stall", stall, 0);
        // counter saturation then trap
        step(); dc_wait = 1;
        repeat (14) step();
        chk("cnt_14", stall_cnt, 14);
        repeat (4) step();
        chk("cnt_sat", stall_cnt, SAT);
        dc_wait = 0; id_illegal_instr = 1; #1;
        chk("ill_stall", stall, 1); chk("ill_trap_early", trap, 0);
        step(); idle(); #1;
        chk("trap_set", trap, 1); chk("trap_stall", stall, 1); chk("trap_bubble", id_ex_bubble, 1);
        step(); chk("trap_cnt", stall_cnt, SAT);
        // randomized traffic, reset sprinkled in to leave HALTED/TRAP
        for (int i = 0; i < 3000; i++) begin
            step();
            rst                 = $urandom_range(0, 59) == 0;
            id_opcode_class     = 3'($urandom_range(0, 6));
            id_ir_rs1           = 5'($urandom_range(0, 3));
            id_ir_rs2           = 5'($urandom_range(0, 3));
            id_cond             = 1'($urandom_range(0, 1));
            id_halt             = $urandom_range(0, 39) == 0;
            id_illegal_instr    = $urandom_range(0, 59) == 0;
            id_ex_opcode_class  = 3'($urandom_range(0, 6));
            id_ex_reg_rd        = 5'($urandom_range(0, 3));
            id_ex_reg_wen       = 1'($urandom_range(0, 1));
            ex_mem_opcode_class = 3'($urandom_range(0, 6));
            ex_mem_reg_rd       = 5'($urandom_range(0, 3));
            ex_mem_reg_wen      = 1'($urandom_range(0, 1));
            dc_wait             = $urandom_range(0, 5) == 0;
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
